rv_find_first_arb: RTL and testbench

- Registered, parametrised successor to the combinational find-first selector.
- Picks one valid channel out of N and returns the grant one-hot to the sources. Latches the selected data plus its channel index into an output register with valid/ready backpressure.
- Supports fixed-priority and round-robin modes, either search direction, and non-power-of-two N.
- Used in front of shared issue/writeback ports where several lanes or warps compete for one slot per cycle.

---
 rtl/rv_find_first_arb.sv | 98 +++++++++
 tb/tb_rv_find_first_arb.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rv_find_first_arb.sv
// Registered find-first arbiter: picks one valid channel (fixed priority or round-robin),
// grants it one-hot and latches its data and index into a valid/ready output register.
module rv_find_first_arb #(
    parameter int unsigned N       = 4,
    parameter int unsigned DATAW   = 2,
    parameter int unsigned REVERSE = 0,
    parameter int unsigned MODE    = 0,
    localparam int unsigned LOGN   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         valid_i,
    input  logic [DATAW*N-1:0]   data_i,
    output logic [N-1:0]         ready_o,
    output logic                 valid_o,
    output logic [DATAW-1:0]     data_o,
    output logic [LOGN-1:0]      index_o,
    input  logic                 ready_i
);

    localparam logic [LOGN-1:0] PtrRst = (REVERSE != 0) ? LOGN'(N - 1) : '0;

    logic             valid_q;
    logic [DATAW-1:0] data_q;
    logic [LOGN-1:0]  index_q;
    logic [LOGN-1:0]  ptr_q, ptr_d;

    logic             load_en;
    logic             grant;
    logic             win_found;
    logic [LOGN-1:0]  win_idx;
    logic [DATAW-1:0] win_data;
    logic [N-1:0]     valid_sh;
    int               cand;
    int               ptr_nxt;

    assign load_en = !valid_q || ready_i;

    // Search starts at ptr_q; in fixed-priority mode ptr_q never leaves its reset value,
    // which is exactly the fixed start point for either direction.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_data  = '0;
        cand      = 0;
        valid_sh  = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (REVERSE != 0) cand = (int'(ptr_q) + int'(N) - k) % int'(N);
            else              cand = (int'(ptr_q) + k) % int'(N);
            valid_sh = valid_i >> cand;
            if (!win_found && valid_sh[0]) begin
                win_found = 1'b1;
                win_idx   = LOGN'(cand);
                win_data  = DATAW'(data_i >> (cand * int'(DATAW)));
            end
        end
    end

    assign grant   = !reset && load_en && win_found;
    assign ready_o = grant ? (N'(1) << win_idx) : '0;

    always_comb begin
        if (REVERSE != 0) ptr_nxt = (int'(win_idx) + int'(N) - 1) % int'(N);
        else              ptr_nxt = (int'(win_idx) + 1) % int'(N);
        ptr_d = ptr_q;
        if (MODE != 0 && grant) ptr_d = LOGN'(ptr_nxt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
            ptr_q   <= PtrRst;
        end else begin
            if (load_en) begin
                valid_q <= win_found;
                if (win_found) begin
                    data_q  <= win_data;
                    index_q <= win_idx;
                end
            end
            ptr_q <= ptr_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign index_o = index_q;

    a_grant_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(ready_o));
    a_grant_valid  : assert property (@(posedge clk) disable iff (reset)
                                      (ready_o & ~valid_i) == '0);
    a_hold_stable  : assert property (@(posedge clk) disable iff (reset)
                                      valid_q && !ready_i |=>
                                      valid_q && $stable(data_q) && $stable(index_q));

endmodule

// File: tb/tb_rv_find_first_arb.sv
// Directed bench for rv_find_first_arb: fixed priority in both directions, round-robin,
// non-power-of-two wrap, backpressure, empty drain and asynchronous reset.
module tb_rv_find_first_arb;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    // Fixed priority, ascending
    logic [3:0]  fp_valid, fp_ready;
    logic [31:0] fp_data;
    logic        fp_vo, fp_rdy;
    logic [7:0]  fp_do;
    logic [1:0]  fp_io;
    // Fixed priority, descending
    logic [3:0]  fr_valid, fr_ready;
    logic [31:0] fr_data;
    logic        fr_vo, fr_rdy;
    logic [7:0]  fr_do;
    logic [1:0]  fr_io;
    // Round-robin, N=4
    logic [3:0]  rr_valid, rr_ready;
    logic [31:0] rr_data;
    logic        rr_vo, rr_rdy;
    logic [7:0]  rr_do;
    logic [1:0]  rr_io;
    // Round-robin, N=5
    logic [4:0]  np_valid, np_ready;
    logic [39:0] np_data;
    logic        np_vo, np_rdy;
    logic [7:0]  np_do;
    logic [2:0]  np_io;

    rv_find_first_arb #(.N(4), .DATAW(8), .REVERSE(0), .MODE(0)) u_fp (
        .clk(clk), .reset(reset), .valid_i(fp_valid), .data_i(fp_data), .ready_o(fp_ready),
        .valid_o(fp_vo), .data_o(fp_do), .index_o(fp_io), .ready_i(fp_rdy));
    rv_find_first_arb #(.N(4), .DATAW(8), .REVERSE(1), .MODE(0)) u_fr (
        .clk(clk), .reset(reset), .valid_i(fr_valid), .data_i(fr_data), .ready_o(fr_ready),
        .valid_o(fr_vo), .data_o(fr_do), .index_o(fr_io), .ready_i(fr_rdy));
    rv_find_first_arb #(.N(4), .DATAW(8), .REVERSE(0), .MODE(1)) u_rr (
        .clk(clk), .reset(reset), .valid_i(rr_valid), .data_i(rr_data), .ready_o(rr_ready),
        .valid_o(rr_vo), .data_o(rr_do), .index_o(rr_io), .ready_i(rr_rdy));
    rv_find_first_arb #(.N(5), .DATAW(8), .REVERSE(0), .MODE(1)) u_np (
        .clk(clk), .reset(reset), .valid_i(np_valid), .data_i(np_data), .ready_o(np_ready),
        .valid_o(np_vo), .data_o(np_do), .index_o(np_io), .ready_i(np_rdy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] rr_seq [5];
        rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        fp_valid = 4'b1010; fp_data = {8'h44, 8'h33, 8'h22, 8'h11}; fp_rdy = 1'b1;
        fr_valid = 4'b0000; fr_data = {8'h44, 8'h33, 8'h22, 8'h11}; fr_rdy = 1'b1;
        rr_valid = 4'b0000; rr_data = {8'hd3, 8'hc2, 8'hb1, 8'ha0}; rr_rdy = 1'b1;
        np_valid = 5'b00000; np_data = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11}; np_rdy = 1'b1;
        step();
        step();

        // Reset state, grant suppressed while reset is high
        check("rst_valid_o", 64'(fp_vo), 64'h0);
        check("rst_data_o", 64'(fp_do), 64'h0);
        check("rst_index_o", 64'(fp_io), 64'h0);
        check("rst_ready_o", 64'(fp_ready), 64'h0);
        reset = 1'b0;
        fr_valid = 4'b1010;
        #1;

        // Fixed priority, both directions
        check("fp_ready_1010", 64'(fp_ready), 64'b0010);
        check("fr_ready_1010", 64'(fr_ready), 64'b1000);
        step();
        check("fp_valid_o", 64'(fp_vo), 64'h1);
        check("fp_data_o", 64'(fp_do), 64'h22);
        check("fp_index_o", 64'(fp_io), 64'd1);
        check("fr_data_o", 64'(fr_do), 64'h44);
        check("fr_index_o", 64'(fr_io), 64'd3);
        fr_valid = 4'b0011;
        #1;
        check("fr_ready_0011", 64'(fr_ready), 64'b0010);
        step();
        check("fr_data_0011", 64'(fr_do), 64'h22);
        fr_valid = 4'b0000;

        // Backpressure: hold 0x22 for three cycles
        fp_valid = 4'b0100;
        fp_rdy   = 1'b0;
        #1;
        check("bp_ready_pre", 64'(fp_ready), 64'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_ready_hold", 64'(fp_ready), 64'h0);
            check("bp_valid_hold", 64'(fp_vo), 64'h1);
            check("bp_data_hold", 64'(fp_do), 64'h22);
            check("bp_index_hold", 64'(fp_io), 64'd1);
        end
        fp_rdy = 1'b1;
        #1;
        check("bp_ready_release", 64'(fp_ready), 64'b0100);
        step();
        check("bp_data_next", 64'(fp_do), 64'h33);
        check("bp_index_next", 64'(fp_io), 64'd2);

        // Empty input drains the held item
        fp_valid = 4'b0000;
        #1;
        check("empty_ready", 64'(fp_ready), 64'h0);
        step();
        check("empty_valid_o", 64'(fp_vo), 64'h0);

        // Round-robin over all four channels
        rr_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("rr_ready_all", 64'(rr_ready), 64'(4'b0001 << rr_seq[i]));
            step();
            check("rr_index_all", 64'(rr_io), 64'(rr_seq[i]));
        end
        check("rr_data_last", 64'(rr_do), 64'ha0);
        // Pointer now 1: search 1,2,3 -> 3, then wraps to 0
        rr_valid = 4'b1001;
        #1;
        check("rr_ready_1001_a", 64'(rr_ready), 64'b1000);
        step();
        check("rr_index_1001_a", 64'(rr_io), 64'd3);
        check("rr_data_1001_a", 64'(rr_do), 64'hd3);
        check("rr_ready_1001_b", 64'(rr_ready), 64'b0001);
        step();
        check("rr_index_1001_b", 64'(rr_io), 64'd0);
        rr_valid = 4'b0000;
        step();
        check("rr_drain", 64'(rr_vo), 64'h0);
        // Empty cycle leaves the pointer at 1
        rr_valid = 4'b0101;
        #1;
        check("rr_ptr_hold", 64'(rr_ready), 64'b0100);
        step();
        rr_valid = 4'b0000;

        // N=5 round-robin: grant 3 moves ptr to 4, then 4 and wrap to 0
        np_valid = 5'b01000;
        #1;
        check("np_ready_3", 64'(np_ready), 64'b01000);
        step();
        np_valid = 5'b10001;
        #1;
        check("np_ready_4", 64'(np_ready), 64'b10000);
        step();
        check("np_index_4", 64'(np_io), 64'd4);
        check("np_data_4", 64'(np_do), 64'h55);
        check("np_ready_wrap", 64'(np_ready), 64'b00001);
        step();
        check("np_index_0", 64'(np_io), 64'd0);
        check("np_data_0", 64'(np_do), 64'h11);
        check("np_ready_again", 64'(np_ready), 64'b10000);
        step();
        check("np_index_again", 64'(np_io), 64'd4);
        np_valid = 5'b00000;

        // Asynchronous reset while an item is held
        fp_valid = 4'b0010;
        step();
        fp_rdy = 1'b0;
        #1;
        check("mid_valid_pre", 64'(fp_vo), 64'h1);
        #1;
        reset = 1'b1;
        #1;
        check("mid_valid_o", 64'(fp_vo), 64'h0);
        check("mid_data_o", 64'(fp_do), 64'h0);
        check("mid_index_o", 64'(fp_io), 64'h0);
        check("mid_ready_o", 64'(fp_ready), 64'h0);
        check("mid_rr_index", 64'(rr_io), 64'h0);
        step();
        reset = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
